// File: rtl/cv32e40p_mult_iter_pkg.sv
// Shared types and constants for the iterative multiplier/MAC.
// Optional early-exit build is selected in the top with CV32E40P_MULT_ITER_EARLY_EXIT_EN.
package cv32e40p_mult_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_iter_state_e;

  localparam int MULT_ITER_SLICE_W_DEFAULT = 8;

endpackage

// File: rtl/cv32e40p_mult_iter_pp.sv
// Combinational signed (WIDTH+1) x (SLICE_W+1) partial-product multiplier.
module cv32e40p_mult_iter_pp #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic [WIDTH:0]           a_i,
  input  logic [SLICE_W:0]         b_i,
  output logic [WIDTH+SLICE_W+1:0] p_o
);

  // Both operands already carry their own extension bit, so a plain signed multiply is exact.
  assign p_o = $signed(a_i) * $signed(b_i);

endmodule

// File: rtl/cv32e40p_mult_iter.sv
// Iterative radix-2^SLICE_W multiplier/MAC with valid/ready handshakes on both sides.
// Define CV32E40P_MULT_ITER_EARLY_EXIT_EN to finish early once the remaining B slices are zero.
module cv32e40p_mult_iter
  import cv32e40p_mult_iter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = MULT_ITER_SLICE_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] op_c_i,
  input  logic [1:0]       signed_i,
  input  logic             acc_en_i,
  input  logic             high_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int K     = WIDTH / SLICE_W;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int PP_W  = WIDTH + SLICE_W + 2;

  mult_iter_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sgn_q, sgn_d;
  logic             high_q, high_d;

  logic             last_slice;
  logic             slice_done;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH:0]   a_ext;
  logic [SLICE_W:0] b_slice;
  logic [PP_W-1:0]  pp;
  logic [ACC_W-1:0] pp_shifted;
  logic             accept;
  logic             unused_acc_top;

  assign last_slice = (cnt_q == CNT_W'(K - 1));
  assign accept     = (state_q == IDLE) && valid_i && !flush_i;

  // Only the top slice of a signed B carries B's sign; lower slices are unsigned digits.
  assign b_shift = b_q >> (int'(cnt_q) * SLICE_W);
  assign a_ext   = {sgn_q[0] & a_q[WIDTH-1], a_q};
  assign b_slice = {last_slice & sgn_q[1] & b_q[WIDTH-1], b_shift[SLICE_W-1:0]};

  cv32e40p_mult_iter_pp #(
    .WIDTH  (WIDTH),
    .SLICE_W(SLICE_W)
  ) u_pp (
    .a_i(a_ext),
    .b_i(b_slice),
    .p_o(pp)
  );

  assign pp_shifted = ACC_W'($signed(pp)) << (int'(cnt_q) * SLICE_W);

`ifdef CV32E40P_MULT_ITER_EARLY_EXIT_EN
  logic [WIDTH-1:0] b_rem;
  assign b_rem      = b_q >> ((int'(cnt_q) + 1) * SLICE_W);
  assign slice_done = last_slice || ((b_rem == '0) && !(sgn_q[1] && b_q[WIDTH-1]));
`else
  assign slice_done = last_slice;
`endif

  // Bits above 2*WIDTH only absorb carries; results wrap modulo 2^(2*WIDTH).
  assign unused_acc_top = ^acc_q[ACC_W-1:2*WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= '0;
      high_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      high_q  <= high_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (slice_done) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    sgn_d  = sgn_q;
    high_d = high_q;
    if (flush_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      a_d    = op_a_i;
      b_d    = op_b_i;
      sgn_d  = signed_i;
      high_d = high_i;
      acc_d  = acc_en_i ? ACC_W'($signed(op_c_i)) : '0;
      cnt_d  = '0;
    end else if (state_q == BUSY) begin
      acc_d = acc_q + pp_shifted;
      cnt_d = slice_done ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    ready_o  = (state_q == IDLE);
    busy_o   = (state_q != IDLE);
    valid_o  = (state_q == DONE);
    result_o = '0;
    if (state_q == DONE) result_o = high_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
  end

endmodule
